// File: rtl/zephyr_trace_buffer.sv
// Trace buffer that snoops CPU state/PC/IR into a circular record memory around a trigger.
// Captured records are read back in oldest-first logical order once the capture is complete.
module zephyr_trace_buffer #(
  parameter int PC_WIDTH    = 4,
  parameter int IR_WIDTH    = 8,
  parameter int STATE_WIDTH = 4,
  parameter int TS_WIDTH    = 16,
  parameter int DEPTH       = 16,
  parameter int POST_TRIG   = 4
) (
  input  logic                                            clk_i,
  input  logic                                            reset_i,
  input  logic                                            arm_i,
  input  logic                                            sample_en_i,
  input  logic [STATE_WIDTH-1:0]                          cpu_state_i,
  input  logic [PC_WIDTH-1:0]                             cpu_pc_i,
  input  logic [IR_WIDTH-1:0]                             cpu_ir_i,
  input  logic [1:0]                                      trig_mode_i,
  input  logic [PC_WIDTH-1:0]                             trig_pc_i,
  input  logic [STATE_WIDTH-1:0]                          trig_state_i,
  input  logic                                            abort_i,
  input  logic                                            rd_req_i,
  input  logic [$clog2(DEPTH)-1:0]                        rd_addr_i,
  output logic                                            rd_valid_o,
  output logic [TS_WIDTH+STATE_WIDTH+PC_WIDTH+IR_WIDTH-1:0] rd_data_o,
  output logic                                            busy_o,
  output logic                                            done_o,
  output logic                                            wrapped_o,
  output logic [$clog2(DEPTH):0]                          count_o,
  output logic [$clog2(DEPTH)-1:0]                        trig_index_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_WIDTH + STATE_WIDTH + PC_WIDTH + IR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

  logic [RW-1:0]       mem [DEPTH];

  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       wptr_q, wptr_d;
  logic [AW:0]         count_q, count_d;
  logic                wrapped_q, wrapped_d;
  logic [AW-1:0]       trig_phys_q, trig_phys_d;
  logic [AW-1:0]       trig_index_q, trig_index_d;
  logic [AW-1:0]       post_cnt_q, post_cnt_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                rd_valid_q, rd_valid_d;
  logic [RW-1:0]       rd_data_q, rd_data_d;

  logic                trig_hit;
  logic                wr_en;
  logic [AW-1:0]       oldest_q, oldest_d, rd_phys;

  always_comb begin
    unique case (trig_mode_i)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = (cpu_pc_i == trig_pc_i);
      2'd2:    trig_hit = (cpu_state_i == trig_state_i);
      default: trig_hit = (cpu_pc_i == trig_pc_i) && (cpu_state_i == trig_state_i);
    endcase
  end

  assign oldest_q = wrapped_q ? wptr_q : '0;
  assign rd_phys  = oldest_q + rd_addr_i;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    count_d      = count_q;
    wrapped_d    = wrapped_q;
    trig_phys_d  = trig_phys_q;
    trig_index_d = trig_index_q;
    post_cnt_d   = post_cnt_q;
    ts_d         = ts_q;
    wr_en        = 1'b0;

    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            state_d      = ST_ARMED;
            wptr_d       = '0;
            count_d      = '0;
            wrapped_d    = 1'b0;
            trig_phys_d  = '0;
            trig_index_d = '0;
            post_cnt_d   = '0;
            ts_d         = '0;
          end
        end
        ST_ARMED, ST_POST: begin
          ts_d = ts_q + 1'b1;
          if (sample_en_i) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
            if (count_q != FULL) count_d = count_q + 1'b1;
            if ((wptr_q == '0) && (count_q == FULL)) wrapped_d = 1'b1;
            if (state_q == ST_ARMED) begin
              if (trig_hit) begin
                trig_phys_d = wptr_q;
                post_cnt_d  = '0;
                state_d     = (POST_TRIG == 0) ? ST_DONE : ST_POST;
              end
            end else if (post_cnt_q == POST_LAST) begin
              state_d = ST_DONE;
            end else begin
              post_cnt_d = post_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The trigger's logical index depends on where the oldest record sits after this cycle's write.
    oldest_d = wrapped_d ? wptr_d : '0;
    if ((state_d == ST_DONE) && (state_q != ST_DONE)) trig_index_d = trig_phys_d - oldest_d;

    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if ((state_q == ST_DONE) && rd_req_i) begin
      rd_valid_d = 1'b1;
      rd_data_d  = ({1'b0, rd_addr_i} >= count_q) ? '0 : mem[rd_phys];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      wptr_q       <= '0;
      count_q      <= '0;
      wrapped_q    <= 1'b0;
      trig_phys_q  <= '0;
      trig_index_q <= '0;
      post_cnt_q   <= '0;
      ts_q         <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      count_q      <= count_d;
      wrapped_q    <= wrapped_d;
      trig_phys_q  <= trig_phys_d;
      trig_index_q <= trig_index_d;
      post_cnt_q   <= post_cnt_d;
      ts_q         <= ts_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Record memory is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en && !reset_i) mem[wptr_q] <= {ts_q, cpu_state_i, cpu_pc_i, cpu_ir_i};
  end

  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign busy_o       = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done_o       = (state_q == ST_DONE);
  assign wrapped_o    = wrapped_q;
  assign count_o      = count_q;
  assign trig_index_o = trig_index_q;

endmodule

// File: tb/tb_zephyr_trace_buffer.sv
// Directed self-checking bench for zephyr_trace_buffer at DEPTH=16, POST_TRIG=4.
// Each sample k drives ir=k and pc=k mod 16; records are {ts,state,pc,ir}.
module tb_zephyr_trace_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic        sampleEn = 1'b0;
  logic [3:0]  cpuState = '0;
  logic [3:0]  cpuPc = '0;
  logic [7:0]  cpuIr = '0;
  logic [1:0]  trigMode = '0;
  logic [3:0]  trigPc = '0;
  logic [3:0]  trigState = '0;
  logic        abortReq = 1'b0;
  logic        rdReq = 1'b0;
  logic [3:0]  rdAddr = '0;
  logic        rdValid;
  logic [31:0] rdData;
  logic        busy;
  logic        done;
  logic        wrapped;
  logic [4:0]  count;
  logic [3:0]  trigIndex;

  int checks = 0;
  int errors = 0;

  zephyr_trace_buffer #(
    .PC_WIDTH(4), .IR_WIDTH(8), .STATE_WIDTH(4), .TS_WIDTH(16), .DEPTH(16), .POST_TRIG(4)
  ) dut (
    .clk_i(clk), .reset_i(reset), .arm_i(arm), .sample_en_i(sampleEn),
    .cpu_state_i(cpuState), .cpu_pc_i(cpuPc), .cpu_ir_i(cpuIr),
    .trig_mode_i(trigMode), .trig_pc_i(trigPc), .trig_state_i(trigState),
    .abort_i(abortReq), .rd_req_i(rdReq), .rd_addr_i(rdAddr),
    .rd_valid_o(rdValid), .rd_data_o(rdData), .busy_o(busy), .done_o(done),
    .wrapped_o(wrapped), .count_o(count), .trig_index_o(trigIndex)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic en, input logic [3:0] st);
    cpuIr    = k[7:0];
    cpuPc    = k[3:0];
    cpuState = st;
    sampleEn = en;
    tick();
  endtask

  function automatic logic [31:0] rec(input int ts, input int st, input int k);
    logic [15:0] t;
    logic [3:0]  s;
    logic [7:0]  i;
    t = ts[15:0];
    s = st[3:0];
    i = k[7:0];
    return {t, s, i[3:0], i};
  endfunction

  task automatic readAddr(input string tag, input logic [3:0] addr, input logic [31:0] expected);
    rdAddr = addr;
    rdReq  = 1'b1;
    tick();
    rdReq  = 1'b0;
    checkOutput({tag, "_valid"}, {63'd0, rdValid}, 64'd1);
    checkOutput({tag, "_data"}, {32'd0, rdData}, {32'd0, expected});
    tick();
    checkOutput({tag, "_valid_drop"}, {63'd0, rdValid}, 64'd0);
  endtask

  task automatic doArm(input logic [1:0] mode);
    trigMode = mode;
    sampleEn = 1'b0;
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    checkOutput("rst_wrapped", {63'd0, wrapped}, 64'd0);
    checkOutput("rst_count", {59'd0, count}, 64'd0);
    checkOutput("rst_trig_index", {60'd0, trigIndex}, 64'd0);
    checkOutput("rst_rd_data", {32'd0, rdData}, 64'd0);
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
    checkOutput("rst_rd_valid", {63'd0, rdValid}, 64'd0);

    // Trigger on the first sample
    doArm(2'd0);
    checkOutput("m0_busy", {63'd0, busy}, 64'd1);
    for (int k = 0; k <= 4; k++) applyStimulus(k, 1'b1, 4'd0);
    checkOutput("m0_done", {63'd0, done}, 64'd1);
    applyStimulus(5, 1'b1, 4'd0);
    sampleEn = 1'b0;
    checkOutput("m0_busy_off", {63'd0, busy}, 64'd0);
    checkOutput("m0_count", {59'd0, count}, 64'd5);
    checkOutput("m0_trig_index", {60'd0, trigIndex}, 64'd0);
    readAddr("m0_rd0", 4'd0, rec(0, 0, 0));
    readAddr("m0_rd4", 4'd4, rec(4, 0, 4));
    readAddr("m0_rd7_empty", 4'd7, 32'd0);

    // PC match
    trigPc = 4'd9;
    doArm(2'd1);
    checkOutput("m1_count_clr", {59'd0, count}, 64'd0);
    for (int k = 0; k <= 12; k++) applyStimulus(k, 1'b1, 4'd0);
    checkOutput("m1_not_done", {63'd0, done}, 64'd0);
    applyStimulus(13, 1'b1, 4'd0);
    sampleEn = 1'b0;
    checkOutput("m1_done", {63'd0, done}, 64'd1);
    checkOutput("m1_count", {59'd0, count}, 64'd14);
    checkOutput("m1_wrapped", {63'd0, wrapped}, 64'd0);
    checkOutput("m1_trig_index", {60'd0, trigIndex}, 64'd9);
    readAddr("m1_rd13", 4'd13, rec(13, 0, 13));

    // State match with wraparound; an ARM during capture is ignored
    trigState = 4'd2;
    doArm(2'd2);
    for (int k = 0; k <= 34; k++) begin
      arm = (k == 20);
      applyStimulus(k, 1'b1, (k == 30) ? 4'd2 : 4'd0);
    end
    arm = 1'b0;
    sampleEn = 1'b0;
    checkOutput("m2_done", {63'd0, done}, 64'd1);
    checkOutput("m2_wrapped", {63'd0, wrapped}, 64'd1);
    checkOutput("m2_count", {59'd0, count}, 64'd16);
    checkOutput("m2_trig_index", {60'd0, trigIndex}, 64'd11);
    readAddr("m2_rd0", 4'd0, rec(19, 0, 19));
    readAddr("m2_rd15", 4'd15, rec(34, 0, 34));
    readAddr("m2_rd11", 4'd11, rec(30, 2, 30));

    // SAMPLE_EN gaps advance ts but not the post count
    doArm(2'd0);
    applyStimulus(0, 1'b1, 4'd0);
    applyStimulus(1, 1'b1, 4'd0);
    for (int g = 0; g < 3; g++) applyStimulus(0, 1'b0, 4'd0);
    applyStimulus(2, 1'b1, 4'd0);
    applyStimulus(3, 1'b1, 4'd0);
    checkOutput("gap_not_done", {63'd0, done}, 64'd0);
    applyStimulus(4, 1'b1, 4'd0);
    sampleEn = 1'b0;
    checkOutput("gap_done", {63'd0, done}, 64'd1);
    checkOutput("gap_count", {59'd0, count}, 64'd5);
    readAddr("gap_rd1", 4'd1, rec(1, 0, 1));
    readAddr("gap_rd2", 4'd2, rec(5, 0, 2));
    readAddr("gap_rd3", 4'd3, rec(6, 0, 3));

    // ABORT beats ARM and keeps COUNT
    doArm(2'd0);
    applyStimulus(0, 1'b1, 4'd0);
    sampleEn = 1'b0;
    abortReq = 1'b1;
    arm      = 1'b1;
    tick();
    abortReq = 1'b0;
    arm      = 1'b0;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_done", {63'd0, done}, 64'd0);
    checkOutput("abort_count", {59'd0, count}, 64'd1);
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
    checkOutput("abort_rd_valid", {63'd0, rdValid}, 64'd0);
    checkOutput("abort_still_idle", {63'd0, busy}, 64'd0);

    // RESET in the second POST cycle
    doArm(2'd0);
    applyStimulus(0, 1'b1, 4'd0);
    applyStimulus(1, 1'b1, 4'd0);
    reset = 1'b1;
    applyStimulus(2, 1'b1, 4'd0);
    reset = 1'b0;
    sampleEn = 1'b0;
    checkOutput("prst_busy", {63'd0, busy}, 64'd0);
    checkOutput("prst_done", {63'd0, done}, 64'd0);
    checkOutput("prst_count", {59'd0, count}, 64'd0);
    checkOutput("prst_rd_data", {32'd0, rdData}, 64'd0);
    doArm(2'd0);
    for (int k = 0; k <= 4; k++) applyStimulus(k, 1'b1, 4'd0);
    sampleEn = 1'b0;
    checkOutput("prst_redo_done", {63'd0, done}, 64'd1);
    checkOutput("prst_redo_count", {59'd0, count}, 64'd5);
    readAddr("prst_rd1", 4'd1, rec(1, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zephyr_trace_buffer.md
ZEPHYR_TRACE_BUFFER -- requirements
Module: zephyr_trace_buffer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 4, width of the sampled PC.
REQ-002 SHALL have parameter IR_WIDTH, default 8, width of the sampled IR.
REQ-003 SHALL have parameter STATE_WIDTH, default 4, width of the sampled control-FSM state.
REQ-004 SHALL have parameter TS_WIDTH, default 16, width of the timestamp.
REQ-005 SHALL have parameter DEPTH, default 16, record count; power of two, at least 4.
REQ-006 SHALL have parameter POST_TRIG, default 4, records captured after the trigger record; legal range 0..DEPTH-1.
REQ-007 SHALL have these ports: CLK, input, 1, sole clock, rising edge.
REQ-008 SHALL have these ports: RESET, input, 1, synchronous active-high reset.
REQ-009 SHALL have these ports: ARM, input, 1, start a capture; SAMPLE_EN, input, 1, the current CPU sample is valid.
REQ-010 SHALL have these ports: CPU_STATE, CPU_PC and CPU_IR, inputs of width STATE_WIDTH, PC_WIDTH and IR_WIDTH, the snooped CPU values.
REQ-011 SHALL have these ports: TRIG_MODE, input, 2, trigger condition: 0 any sample, 1 PC match, 2 state match, 3 PC and state match.
REQ-012 SHALL have these ports: TRIG_PC and TRIG_STATE, inputs, the match values.
REQ-013 SHALL have these ports: ABORT, input, 1, return to IDLE and keep the buffer contents.
REQ-014 SHALL have these ports: RD_REQ, input, 1, readout request; RD_ADDR, input, log2(DEPTH), logical index where 0 is the oldest record.
REQ-015 SHALL have these ports: RD_VALID, output, 1; RD_DATA, output, TS_WIDTH+STATE_WIDTH+PC_WIDTH+IR_WIDTH, record packed as {ts,state,pc,ir}.
REQ-016 SHALL have these ports: BUSY, DONE and WRAPPED, outputs, 1 each.
REQ-017 SHALL have these ports: COUNT, output, log2(DEPTH)+1, number of valid records; TRIG_INDEX, output, log2(DEPTH), logical index of the trigger record.

Function
REQ-018 SHALL implement the FSM IDLE, ARMED, POST, DONE: IDLE->ARMED on ARM; ARMED->POST on trigger when POST_TRIG>0; ARMED->DONE on trigger when POST_TRIG=0; POST->DONE after POST_TRIG post records; DONE->ARMED on ARM.
REQ-019 SHALL, on ARM acceptance (from IDLE or DONE), clear the write pointer, COUNT, WRAPPED, TRIG_INDEX and the timestamp, and SHALL NOT sample in the ARM cycle itself.
REQ-020 SHALL ignore ARM while in ARMED or POST.
REQ-021 SHALL increment the timestamp every cycle in ARMED and POST regardless of SAMPLE_EN, wrap it modulo 2^TS_WIDTH, and hold it otherwise.
REQ-022 SHALL, in ARMED and POST, write one record {ts,CPU_STATE,CPU_PC,CPU_IR} at the write pointer on each cycle with SAMPLE_EN=1, advancing the pointer modulo DEPTH; no write when SAMPLE_EN=0.
REQ-023 SHALL evaluate the trigger only in ARMED and only on cycles with SAMPLE_EN=1; the triggering sample is itself recorded.
REQ-024 SHALL make COUNT saturate at DEPTH and set WRAPPED when a write lands on slot 0 after DEPTH prior writes; WRAPPED stays set until the next ARM or RESET.
REQ-025 SHALL count, in POST, only the SAMPLE_EN=1 cycles toward POST_TRIG, and SHALL enter DONE in the cycle after the last post record is written.
REQ-026 SHALL, on entering DONE, fix TRIG_INDEX to the trigger record's logical index (physical index minus oldest index, mod DEPTH).
REQ-027 SHALL define the oldest physical slot as the write pointer when WRAPPED=1, and as 0 otherwise.
REQ-028 SHALL service readout in DONE only: RD_REQ produces RD_VALID=1 exactly one cycle later, with RD_DATA taken from physical slot (oldest+RD_ADDR) mod DEPTH.
REQ-029 SHALL, for RD_ADDR>=COUNT, return RD_DATA=0 with RD_VALID=1.
REQ-030 SHALL ignore RD_REQ outside DONE, keeping RD_VALID=0 and RD_DATA unchanged.
REQ-031 SHALL hold BUSY=1 exactly in ARMED and POST, and DONE=1 exactly in the DONE state.
REQ-032 SHALL, on ABORT in any state, go to IDLE next cycle, keep memory, COUNT and WRAPPED, and drop DONE.
REQ-033 SHALL give ABORT priority over ARM when both are asserted in the same cycle.

Reset
REQ-034 SHALL, with RESET=1 on a rising edge, force IDLE and set BUSY, DONE, WRAPPED, COUNT, TRIG_INDEX, RD_VALID, RD_DATA, the timestamp and all pointers and counters to 0.
REQ-035 SHALL give RESET priority over every other input, and SHALL NOT require the record memory to be cleared.

Verification (DEPTH=16, POST_TRIG=4; each sample k drives CPU_IR=k, CPU_PC=k mod 16)
REQ-036 SHALL cover: RESET for 1 cycle -> all outputs 0, BUSY=0, and RD_REQ gives no RD_VALID.
REQ-037 SHALL cover: ARM with TRIG_MODE=0, then samples k=0..5 back-to-back -> DONE after k=4, COUNT=5, TRIG_INDEX=0, RD_ADDR=0 returns ir=0 and ts=0.
REQ-038 SHALL cover: TRIG_MODE=1 and TRIG_PC=9, with samples k=0.. -> trigger at k=9, COUNT=14, WRAPPED=0, TRIG_INDEX=9, RD_ADDR=13 returns ir=13.
REQ-039 SHALL cover: TRIG_MODE=2 and TRIG_STATE=2, with CPU_STATE=2 only at k=30 -> WRAPPED=1, COUNT=16, TRIG_INDEX=11, RD_ADDR=0 returns ir=19, RD_ADDR=15 returns ir=34.
REQ-040 SHALL cover: SAMPLE_EN low for 3 cycles between k=1 and k=2, with TRIG_MODE=0 -> records ts 0,1,5 for k=0,1,2; those gaps are not counted toward POST_TRIG.
REQ-041 SHALL cover: RESET in the second POST cycle -> IDLE, DONE=0, COUNT=0; a following ARM with TRIG_MODE=0 captures normally.
